// File: rtl/div_cmp_sub_unit_if.sv
// Bus bundle for the divider compare/subtract/zero-detect unit.
// The master drives operands; the slave returns registered results.
interface div_cmp_sub_unit_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] cnt;
  logic             out_valid;
  logic             lt;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             b_zero;
  logic             cnt_zero;

  modport master (
    output in_valid, a, b, cnt,
    input  out_valid, lt, diff, borrow, b_zero, cnt_zero
  );

  modport slave (
    input  in_valid, a, b, cnt,
    output out_valid, lt, diff, borrow, b_zero, cnt_zero
  );
endinterface

// File: rtl/div_cmp_sub_unit.sv
// Registered compare / subtract / zero-detect unit for a restoring divider.
// Three small combinational helpers feed a single output register stage.

// Unsigned less-than comparator.
module div_cmp_sub_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt
);
  assign lt = (a < b);
endmodule

// Modulo-2^WIDTH subtractor; the extra top bit of the widened difference
// is the borrow-out, which equals (a < b) for unsigned operands.
module div_cmp_sub_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  logic [WIDTH:0] wide;

  assign wide   = {1'b0, a} - {1'b0, b};
  assign diff   = wide[WIDTH-1:0];
  assign borrow = wide[WIDTH];
endmodule

// NOR-reduction: high when every bit of the operand is zero.
module div_cmp_sub_nor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] val,
  output logic             zero
);
  assign zero = ~|val;
endmodule

module div_cmp_sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  div_cmp_sub_unit_if.slave   bus
);
  logic             lt_next;
  logic [WIDTH-1:0] diff_next;
  logic             borrow_next;
  logic             b_zero_next;
  logic             cnt_zero_next;

  logic             out_valid_reg;
  logic             lt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             b_zero_reg;
  logic             cnt_zero_reg;

  div_cmp_sub_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a  (bus.a),
    .b  (bus.b),
    .lt (lt_next)
  );

  div_cmp_sub_sub #(.WIDTH(WIDTH)) u_sub (
    .a      (bus.a),
    .b      (bus.b),
    .diff   (diff_next),
    .borrow (borrow_next)
  );

  div_cmp_sub_nor #(.WIDTH(WIDTH)) u_b_zero (
    .val  (bus.b),
    .zero (b_zero_next)
  );

  div_cmp_sub_nor #(.WIDTH(WIDTH)) u_cnt_zero (
    .val  (bus.cnt),
    .zero (cnt_zero_next)
  );

  // Capture results on in_valid; otherwise hold data and drop the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      lt_reg        <= 1'b0;
      diff_reg      <= '0;
      borrow_reg    <= 1'b0;
      b_zero_reg    <= 1'b0;
      cnt_zero_reg  <= 1'b0;
    end else if (bus.in_valid) begin
      out_valid_reg <= 1'b1;
      lt_reg        <= lt_next;
      diff_reg      <= diff_next;
      borrow_reg    <= borrow_next;
      b_zero_reg    <= b_zero_next;
      cnt_zero_reg  <= cnt_zero_next;
    end else begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.lt        = lt_reg;
  assign bus.diff      = diff_reg;
  assign bus.borrow    = borrow_reg;
  assign bus.b_zero    = b_zero_reg;
  assign bus.cnt_zero  = cnt_zero_reg;
endmodule

// File: tb/tb_div_cmp_sub_unit.sv
// Self-checking bench for div_cmp_sub_unit (WIDTH = 4): directed vector
// table followed by an exhaustive sweep over all (a, b) pairs.
module tb_div_cmp_sub_unit;
  localparam int WIDTH = 4;

  typedef struct packed {
    logic             valid;
    logic             lt;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             bz;
    logic             cz;
  } res_t;

  typedef struct {
    logic             rst;
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] cnt;
    res_t             exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  res_t sb[$];

  div_cmp_sub_unit_if #(.WIDTH(WIDTH)) bus ();

  div_cmp_sub_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t mk_res(input logic valid, input logic lt,
                                  input logic [WIDTH-1:0] diff, input logic borrow,
                                  input logic bz, input logic cz);
    res_t r;
    r.valid  = valid;
    r.lt     = lt;
    r.diff   = diff;
    r.borrow = borrow;
    r.bz     = bz;
    r.cz     = cz;
    return r;
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input int a, input int b,
                              input int c, input res_t e);
    vec_t t;
    t.rst = r;
    t.v   = v;
    t.a   = WIDTH'(a);
    t.b   = WIDTH'(b);
    t.cnt = WIDTH'(c);
    t.exp = e;
    return t;
  endfunction

  // Reference: arithmetic done on plain integers, reduced to WIDTH bits.
  function automatic res_t ref_model(input int a, input int b, input int c);
    int d;
    d = (a - b + (1 << WIDTH)) % (1 << WIDTH);
    return mk_res(1'b1, a < b, WIDTH'(d), a < b, b == 0, c == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    res_t got;
    @(negedge clk);
    rst          = t.rst;
    bus.in_valid = t.v;
    bus.a        = t.a;
    bus.b        = t.b;
    bus.cnt      = t.cnt;
    if (t.rst) sb.delete();
    else if (t.v) sb.push_back(t.exp);
    @(posedge clk);
    #1;
    $display("rst=%0b v=%0b a=%0d b=%0d cnt=%0d -> ov=%0b lt=%0b diff=%0d brw=%0b bz=%0b cz=%0b",
             t.rst, t.v, t.a, t.b, t.cnt, bus.out_valid, bus.lt, bus.diff,
             bus.borrow, bus.b_zero, bus.cnt_zero);
    chk("out_valid", 32'(bus.out_valid), 32'(t.exp.valid));
    chk("lt",        32'(bus.lt),        32'(t.exp.lt));
    chk("diff",      32'(bus.diff),      32'(t.exp.diff));
    chk("borrow",    32'(bus.borrow),    32'(t.exp.borrow));
    chk("b_zero",    32'(bus.b_zero),    32'(t.exp.bz));
    chk("cnt_zero",  32'(bus.cnt_zero),  32'(t.exp.cz));
    chk("borrow_eq_lt", 32'(bus.borrow), 32'(bus.lt));
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: got out_valid 1 expected no pending result");
      end else begin
        got = sb.pop_front();
        chk("sb_lt",   32'(bus.lt),   32'(got.lt));
        chk("sb_diff", 32'(bus.diff), 32'(got.diff));
      end
    end
  endtask

  initial begin
    vec_t tbl[13];
    res_t z;
    res_t last;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cnt      = '0;

    z = mk_res(0, 0, 0, 0, 0, 0);
    tbl[0]  = mk(1, 1, 5, 3, 0, z);
    tbl[1]  = mk(1, 1, 5, 3, 0, z);
    tbl[2]  = mk(0, 1, 9, 4, 2,   mk_res(1, 0, 5, 0, 0, 0));
    tbl[3]  = mk(0, 1, 3, 7, 1,   mk_res(1, 1, 12, 1, 0, 0));
    tbl[4]  = mk(0, 1, 0, 15, 15, mk_res(1, 1, 1, 1, 0, 0));
    tbl[5]  = mk(0, 1, 6, 6, 0,   mk_res(1, 0, 0, 0, 0, 1));
    tbl[6]  = mk(0, 1, 10, 0, 3,  mk_res(1, 0, 10, 0, 1, 0));
    tbl[7]  = mk(0, 1, 9, 4, 2,   mk_res(1, 0, 5, 0, 0, 0));
    tbl[8]  = mk(0, 0, 1, 8, 0,   mk_res(0, 0, 5, 0, 0, 0));
    tbl[9]  = mk(0, 0, 2, 9, 0,   mk_res(0, 0, 5, 0, 0, 0));
    tbl[10] = mk(1, 1, 5, 3, 0, z);
    tbl[11] = mk(0, 0, 5, 3, 0, z);
    tbl[12] = mk(0, 1, 3, 7, 0,   mk_res(1, 1, 12, 1, 0, 1));

    for (int i = 0; i < 13; i++) step(tbl[i]);

    // Exhaustive back-to-back sweep, cnt follows a.
    for (int a = 0; a < (1 << WIDTH); a++) begin
      for (int b = 0; b < (1 << WIDTH); b++) begin
        step(mk(0, 1, a, b, a, ref_model(a, b, a)));
      end
    end

    // Idle cycle after the sweep: valid drops, last result is held.
    last = ref_model((1 << WIDTH) - 1, (1 << WIDTH) - 1, (1 << WIDTH) - 1);
    last.valid = 1'b0;
    step(mk(0, 0, 0, 1, 0, last));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
